// File: rtl/count_to_sync.sv
// -----------------------------------------------------------------------------
// count_to_sync
//
// Purpose:
//   VGA-style sync generator. Free-running column/row counters are decoded into
//   horizontal and vertical sync pulses, an active-video flag and a frame-start
//   strobe. Every output is registered from the same counter values, so the
//   count outputs always name the coordinate that produced the flags beside
//   them (one cycle of latency from the counters).
//
// Ports:
//   i_Clk          pixel clock, rising edge
//   i_Reset        asynchronous active-high reset
//   i_Enable       1 = timing runs, 0 = held idle at start of frame
//   o_HSync        horizontal sync (polarity set by SYNC_ACTIVE_HIGH)
//   o_VSync        vertical sync (polarity set by SYNC_ACTIVE_HIGH)
//   o_Active       1 while (col,row) lies in the visible area
//   o_Frame_Start  one-cycle pulse when the outputs show (0,0)
//   o_Col_Count    column of the current output cycle
//   o_Row_Count    row of the current output cycle
// -----------------------------------------------------------------------------
module count_to_sync #(
  parameter int ACTIVE_COLS      = 640,
  parameter int H_FRONT_PORCH    = 16,
  parameter int H_SYNC_WIDTH     = 96,
  parameter int H_BACK_PORCH     = 48,
  parameter int ACTIVE_ROWS      = 480,
  parameter int V_FRONT_PORCH    = 10,
  parameter int V_SYNC_WIDTH     = 2,
  parameter int V_BACK_PORCH     = 33,
  parameter int SYNC_ACTIVE_HIGH = 0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Enable,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic       o_Frame_Start,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count
);

  localparam int TOTAL_COLS = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);

  // Decode boundaries are held at 11 bits: a sync window ending exactly at a
  // 1024-long line would otherwise truncate its end bound to 0.
  localparam logic [10:0] H_ACTIVE_END = 11'(ACTIVE_COLS);
  localparam logic [10:0] H_SYNC_START = 11'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [10:0] H_SYNC_END   = 11'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [10:0] V_ACTIVE_END = 11'(ACTIVE_ROWS);
  localparam logic [10:0] V_SYNC_START = 11'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [10:0] V_SYNC_END   = 11'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

  localparam logic SYNC_IDLE     = (SYNC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_ASSERTED = ~SYNC_IDLE;

  // ---------------------------------------------------------------------------
  // Counter state
  // ---------------------------------------------------------------------------
  logic [9:0] col_reg;
  logic [9:0] row_reg;
  logic       en_reg;

  logic       col_wrap;
  logic       row_wrap;

  assign col_wrap = (col_reg == COL_LAST);
  assign row_wrap = (row_reg == ROW_LAST);

  // en_reg remembers that the previous cycle was enabled. The counters only
  // advance once en_reg is set, so the first enabled cycle holds them at (0,0)
  // while the output stage is still idle; the following edge then presents
  // (0,0) with the frame-start strobe instead of skipping column 0.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      en_reg <= 1'b0;
    end else begin
      en_reg <= i_Enable;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (!i_Enable) begin
      // Dropping enable abandons the frame; it restarts from (0,0).
      col_reg <= '0;
      row_reg <= '0;
    end else if (en_reg) begin
      if (col_wrap) begin
        col_reg <= '0;
        row_reg <= row_wrap ? 10'd0 : row_reg + 10'd1;
      end else begin
        col_reg <= col_reg + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the current counter values
  // ---------------------------------------------------------------------------
  logic [10:0] col_ext;
  logic [10:0] row_ext;
  logic        hsync_dec;
  logic        vsync_dec;
  logic        active_dec;
  logic        frame_start_dec;

  assign col_ext = {1'b0, col_reg};
  assign row_ext = {1'b0, row_reg};

  always_comb begin
    hsync_dec       = 1'b0;
    vsync_dec       = 1'b0;
    active_dec      = 1'b0;
    frame_start_dec = 1'b0;

    if ((col_ext >= H_SYNC_START) && (col_ext < H_SYNC_END)) begin
      hsync_dec = 1'b1;
    end
    // Row-only decode: VSync edges therefore land on column-0 boundaries.
    if ((row_ext >= V_SYNC_START) && (row_ext < V_SYNC_END)) begin
      vsync_dec = 1'b1;
    end
    if ((col_ext < H_ACTIVE_END) && (row_ext < V_ACTIVE_END)) begin
      active_dec = 1'b1;
    end
    if ((col_reg == 10'd0) && (row_reg == 10'd0)) begin
      frame_start_dec = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: every output loads from the same counter snapshot, gated by
  // en_reg so that a disabled generator shows idle syncs and zero counts.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_HSync       <= SYNC_IDLE;
      o_VSync       <= SYNC_IDLE;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
    end else if (en_reg) begin
      o_HSync       <= hsync_dec ? SYNC_ASSERTED : SYNC_IDLE;
      o_VSync       <= vsync_dec ? SYNC_ASSERTED : SYNC_IDLE;
      o_Active      <= active_dec;
      o_Frame_Start <= frame_start_dec;
      o_Col_Count   <= col_reg;
      o_Row_Count   <= row_reg;
    end else begin
      o_HSync       <= SYNC_IDLE;
      o_VSync       <= SYNC_IDLE;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
    end
  end

endmodule

// File: tb/tb_count_to_sync.sv
// -----------------------------------------------------------------------------
// tb_count_to_sync
//
// Two instances: dut_a with default VGA timing (active-low syncs) and dut_b
// with a tiny 12x7 timing and active-high syncs. A position-based model pushes
// the expected output word into a queue when each cycle's stimulus is driven;
// the word is popped and compared once the DUT has clocked that cycle.
// -----------------------------------------------------------------------------
module tb_count_to_sync;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       fs;
    logic [9:0] col;
    logic [9:0] row;
  } out_t;

  // Per-instance timing: index 0 = dut_a, 1 = dut_b
  localparam int HA [0:1] = '{640, 8};
  localparam int HF [0:1] = '{16, 1};
  localparam int HW [0:1] = '{96, 2};
  localparam int HB [0:1] = '{48, 1};
  localparam int VA [0:1] = '{480, 4};
  localparam int VF [0:1] = '{10, 1};
  localparam int VW [0:1] = '{2, 1};
  localparam int VB [0:1] = '{33, 1};
  localparam int POL [0:1] = '{0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, en_a = 1'b0;
  logic rst_b = 1'b1, en_b = 1'b0;

  logic       hs_a, vs_a, act_a, fs_a;
  logic [9:0] col_a, row_a;
  logic       hs_b, vs_b, act_b, fs_b;
  logic [9:0] col_b, row_b;
  out_t       obs_a, obs_b;

  assign obs_a = {hs_a, vs_a, act_a, fs_a, col_a, row_a};
  assign obs_b = {hs_b, vs_b, act_b, fs_b, col_b, row_b};

  count_to_sync dut_a (
    .i_Clk(clk), .i_Reset(rst_a), .i_Enable(en_a),
    .o_HSync(hs_a), .o_VSync(vs_a), .o_Active(act_a), .o_Frame_Start(fs_a),
    .o_Col_Count(col_a), .o_Row_Count(row_a)
  );

  count_to_sync #(
    .ACTIVE_COLS(8), .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .H_BACK_PORCH(1),
    .ACTIVE_ROWS(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1),
    .SYNC_ACTIVE_HIGH(1)
  ) dut_b (
    .i_Clk(clk), .i_Reset(rst_b), .i_Enable(en_b),
    .o_HSync(hs_b), .o_VSync(vs_b), .o_Active(act_b), .o_Frame_Start(fs_b),
    .o_Col_Count(col_b), .o_Row_Count(row_b)
  );

  int   total = 0;
  int   bad   = 0;
  int   pos [0:1];
  bit   enq [0:1];
  out_t q_a [$];
  out_t q_b [$];
  out_t cur, prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int tc(input int k);
    return HA[k] + HF[k] + HW[k] + HB[k];
  endfunction

  function automatic int tr(input int k);
    return VA[k] + VF[k] + VW[k] + VB[k];
  endfunction

  function automatic out_t expect_out(input int k, input int col, input int row, input bit on);
    out_t o;
    logic idle;
    idle  = (POL[k] != 0) ? 1'b0 : 1'b1;
    o.hs  = idle;
    o.vs  = idle;
    o.act = 1'b0;
    o.fs  = 1'b0;
    o.col = '0;
    o.row = '0;
    if (on) begin
      if (col >= HA[k] + HF[k] && col < HA[k] + HF[k] + HW[k]) o.hs = ~idle;
      if (row >= VA[k] + VF[k] && row < VA[k] + VF[k] + VW[k]) o.vs = ~idle;
      o.act = (col < HA[k]) && (row < VA[k]);
      o.fs  = (col == 0) && (row == 0);
      o.col = 10'(col);
      o.row = 10'(row);
    end
    return o;
  endfunction

  task automatic reset_model(input int k);
    pos[k] = 0;
    enq[k] = 1'b0;
    if (k == 0) q_a.delete(); else q_b.delete();
  endtask

  // One clock of instance k; called at a falling edge, returns at the next one.
  task automatic tick(input int k, input logic en);
    out_t e, got, r;
    bit   was_on;
    if (k == 0) en_a = en; else en_b = en;
    was_on = enq[k];
    e = expect_out(k, pos[k] % tc(k), pos[k] / tc(k), was_on);
    if (k == 0) q_a.push_back(e); else q_b.push_back(e);
    if (!en) begin
      pos[k] = 0;
      enq[k] = 1'b0;
    end else begin
      if (enq[k]) pos[k] = (pos[k] + 1) % (tc(k) * tr(k));
      enq[k] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    got = (k == 0) ? obs_a : obs_b;
    e   = (k == 0) ? q_a.pop_front() : q_b.pop_front();
    check("scoreboard", {8'd0, got}, {8'd0, e});
    if (was_on) begin
      r = expect_out(k, int'(got.col), int'(got.row), 1'b1);
      check("align", {29'd0, got.hs, got.vs, got.act}, {29'd0, r.hs, r.vs, r.act});
    end
    prev = cur;
    cur  = got;
  endtask

  initial begin
    int hs_low, act_n, cyc, vs_hi;
    reset_model(0);
    reset_model(1);
    cur  = '0;
    prev = '0;

    // ---------------- dut_a: default timing, active-low syncs --------------
    repeat (3) @(negedge clk);
    check("a_rst_state", {8'd0, obs_a}, {8'd0, 2'b11, 22'd0});
    rst_a = 1'b0;
    repeat (302) tick(0, 1'b1);
    check("a_col300", {22'd0, cur.col}, 32'd300);

    // Asynchronous reset mid-line: outputs must drop before the next edge
    #2 rst_a = 1'b1;
    #1 check("a_async_rst", {8'd0, obs_a}, {8'd0, 2'b11, 22'd0});
    @(negedge clk);
    rst_a = 1'b0;
    reset_model(0);
    tick(0, 1'b1);
    check("a_rel_idle", {8'd0, cur}, {8'd0, 2'b11, 22'd0});
    tick(0, 1'b1);
    check("a_rel_fs", {10'd0, cur.fs, cur.act, cur.col, cur.row}, {10'd0, 2'b11, 20'd0});

    // One full line of horizontal timing
    hs_low = 0;
    act_n  = 0;
    for (int i = 0; i < 800; i++) begin
      tick(0, 1'b1);
      if (!cur.hs) hs_low++;
      if (cur.act) act_n++;
      if (cur.col == 10'd0) begin
        check("a_wrap_prev", {22'd0, prev.col}, 32'd799);
        check("a_wrap_row", {22'd0, cur.row}, {22'd0, prev.row + 10'd1});
      end
    end
    check("a_hs_low", hs_low, 96);
    check("a_act_cnt", act_n, 640);

    // Enable gating at (123,1)
    repeat (123) tick(0, 1'b1);
    check("a_at_123", {12'd0, cur.col, cur.row}, {12'd0, 10'd123, 10'd1});
    repeat (10) tick(0, 1'b0);
    check("a_dis_idle", {8'd0, cur}, {8'd0, 2'b11, 22'd0});
    tick(0, 1'b1);
    tick(0, 1'b1);
    check("a_reen_fs", {10'd0, cur.fs, cur.act, cur.col, cur.row}, {10'd0, 2'b11, 20'd0});
    for (int i = 1; i <= 20; i++) begin
      tick(0, 1'b1);
      check("a_reen_cnt", {22'd0, cur.col}, i);
    end
    en_a  = 1'b0;
    rst_a = 1'b1;

    // ---------------- dut_b: 12x7 timing, active-high syncs ----------------
    check("b_rst_state", {8'd0, obs_b}, 32'd0);
    rst_b = 1'b0;
    reset_model(1);
    tick(1, 1'b1);
    tick(1, 1'b1);
    check("b_rel_fs", {10'd0, cur.fs, cur.act, cur.col, cur.row}, {10'd0, 2'b11, 20'd0});
    cyc   = 0;
    vs_hi = 0;
    for (int i = 0; i < 3 * 84; i++) begin
      tick(1, 1'b1);
      cyc++;
      if (cur.vs) vs_hi++;
      if (cur.hs) check("b_hs_col", {31'd0, (cur.col == 10'd9) || (cur.col == 10'd10)}, 32'd1);
      if (cur.vs && !prev.vs)
        check("b_vs_edge", {12'd0, cur.col, cur.row}, {12'd0, 10'd0, 10'd5});
      if (cur.fs) begin
        check("b_period", cyc, 84);
        check("b_vs_frame", vs_hi, 12);
        check("b_wrap_prev", {12'd0, prev.col, prev.row}, {12'd0, 10'd11, 10'd6});
        cyc   = 0;
        vs_hi = 0;
      end
    end
    check("b_fs_seen", cyc, 0);
    check("q_empty", q_a.size() + q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
